// File: rtl/key_entry_pkg.sv
// key_entry_pkg: shared definitions for the keypad command-entry block.
//   - key code constants (digits are 0..9, operators 10..14, '=' is 15)
//   - one-hot ALU opcode constants driven onto ALU_OP
//   - entry state encodings, also visible on entry_st
//   - small classification / decode helpers used by key_entry_fsm
package key_entry_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_AND = 4'd12;
  localparam logic [3:0] KEY_OR  = 4'd13;
  localparam logic [3:0] KEY_CMP = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  localparam logic [7:0] OP_NONE = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h04;
  localparam logic [7:0] OP_OR   = 8'h08;
  localparam logic [7:0] OP_CMP  = 8'h10;

  typedef enum logic [1:0] {
    S_SRC  = 2'd0,
    S_DST  = 2'd1,
    S_DONE = 2'd2
  } entry_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  function automatic logic is_operator(input logic [3:0] code);
    return (code >= KEY_ADD) && (code <= KEY_CMP);
  endfunction

  function automatic logic [7:0] op_onehot(input logic [3:0] code);
    logic [7:0] op;
    case (code)
      KEY_ADD: op = OP_ADD;
      KEY_SUB: op = OP_SUB;
      KEY_AND: op = OP_AND;
      KEY_OR:  op = OP_OR;
      KEY_CMP: op = OP_CMP;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/key_holdoff_filter.sv
// key_holdoff_filter: suppresses auto-repeat of a held key.
//   After a key is accepted, further strobes with the same code are dropped
//   until HOLDOFF_CYCLES clocks have elapsed; a different code is accepted
//   immediately and restarts the window. Only used when KEY_HOLDOFF_EN is defined.
// Ports:
//   clk        in  system clock
//   reset      in  synchronous active-high reset (clears counter and last code)
//   key_valid  in  raw key strobe from the scanner
//   key_code   in  4-bit key code
//   acc_valid  out key strobe that survived the filter (same cycle as key_valid)
module key_holdoff_filter #(
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       acc_valid
);

  localparam int             CW      = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(HOLDOFF_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [3:0]    last_q;
  logic          have_q;   // no key accepted since reset: nothing to compare against

  assign acc_valid = key_valid & (~have_q | (key_code != last_q) | (cnt_q == CNT_MAX));

  // Track the last accepted code and the clocks elapsed since it was accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      last_q <= 4'd0;
      have_q <= 1'b0;
    end else if (acc_valid) begin
      cnt_q  <= '0;
      last_q <= key_code;
      have_q <= 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q  <= cnt_q + CW'(1);
    end else begin
      cnt_q  <= cnt_q;
    end
  end

endmodule

// File: rtl/key_entry_fsm.sv
// key_entry_fsm: assembles an ALU command from keypad key codes.
//   Builds two BCD operands (SRC, DST, up to MAX_DIGITS digits each) and a
//   one-hot opcode, then raises finish on '='. All outputs are registered.
// Optional feature: define KEY_HOLDOFF_EN to enable same-key repeat
//   suppression (key_holdoff_filter, window HOLDOFF_CYCLES clocks).
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset (wins over key_valid)
//   key_valid  in   one-cycle strobe, key_code holds a new key
//   key_code   in   0-9 digit, 10 '+', 11 '-', 12 AND, 13 OR, 14 CMP, 15 '='
//   SRCH/SRCL  out  SRC BCD digits [15:8] / [7:0]
//   DSTH/DSTL  out  DST BCD digits [15:8] / [7:0]
//   ALU_OP     out  one-hot opcode
//   finish     out  high while a complete command is presented
//   entry_st   out  current state (S_SRC 0, S_DST 1, S_DONE 2)
module key_entry_fsm
  import key_entry_pkg::*;
#(
  parameter int MAX_DIGITS     = 4,
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] SRCH,
  output logic [7:0] SRCL,
  output logic [7:0] DSTH,
  output logic [7:0] DSTL,
  output logic [7:0] ALU_OP,
  output logic       finish,
  output logic [1:0] entry_st
);

  localparam logic [2:0] MAX_D = 3'(MAX_DIGITS);

  logic         acc_valid;
  entry_state_e state_q;
  logic [15:0]  src_q;
  logic [15:0]  dst_q;
  logic [2:0]   src_cnt_q;
  logic [2:0]   dst_cnt_q;
  logic [7:0]   op_q;
  logic         finish_q;

`ifdef KEY_HOLDOFF_EN
  key_holdoff_filter #(
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_holdoff (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .acc_valid (acc_valid)
  );
`else
  localparam int unused_holdoff_cycles = HOLDOFF_CYCLES;
  assign acc_valid = key_valid;
`endif

  // Entry FSM: operand shifting, opcode latching and finish handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_SRC;
      src_q     <= 16'h0000;
      dst_q     <= 16'h0000;
      src_cnt_q <= 3'd0;
      dst_cnt_q <= 3'd0;
      op_q      <= OP_NONE;
      finish_q  <= 1'b0;
    end else begin
      case (state_q)
        S_SRC: begin
          if (acc_valid && is_digit(key_code)) begin
            if (src_cnt_q < MAX_D) begin
              src_q     <= {src_q[11:0], key_code};
              src_cnt_q <= src_cnt_q + 3'd1;
            end
          end else if (acc_valid && is_operator(key_code)) begin
            op_q    <= op_onehot(key_code);
            state_q <= S_DST;
          end
        end
        S_DST: begin
          if (acc_valid && is_digit(key_code)) begin
            if (dst_cnt_q < MAX_D) begin
              dst_q     <= {dst_q[11:0], key_code};
              dst_cnt_q <= dst_cnt_q + 3'd1;
            end
          end else if (acc_valid && is_operator(key_code)) begin
            // Operator chains before any DST digit: the last one wins.
            if (dst_cnt_q == 3'd0) begin
              op_q <= op_onehot(key_code);
            end
          end else if (acc_valid && (key_code == KEY_EQ)) begin
            finish_q <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          // A digit starts the next command with that digit already in SRC.
          if (acc_valid && is_digit(key_code)) begin
            src_q     <= {12'h000, key_code};
            src_cnt_q <= 3'd1;
            dst_q     <= 16'h0000;
            dst_cnt_q <= 3'd0;
            op_q      <= OP_NONE;
            finish_q  <= 1'b0;
            state_q   <= S_SRC;
          end
        end
        default: begin
          state_q   <= S_SRC;
          src_q     <= 16'h0000;
          dst_q     <= 16'h0000;
          src_cnt_q <= 3'd0;
          dst_cnt_q <= 3'd0;
          op_q      <= OP_NONE;
          finish_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SRCH     = src_q[15:8];
  assign SRCL     = src_q[7:0];
  assign DSTH     = dst_q[15:8];
  assign DSTL     = dst_q[7:0];
  assign ALU_OP   = op_q;
  assign finish   = finish_q;
  assign entry_st = state_q;

endmodule

// File: tb/tb_key_entry_fsm.sv
// Bench for key_entry_fsm: directed sequences with literal expectations plus
// randomized key streams, all compared every cycle against a digit-list model.
module tb_key_entry_fsm;

  localparam int MAXD = 4;
`ifdef KEY_HOLDOFF_EN
  localparam int HOLD = 8;
`else
  localparam int HOLD = 1000;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [7:0] SRCH, SRCL, DSTH, DSTL, ALU_OP;
  logic       finish;
  logic [1:0] entry_st;

  always #5 clk = ~clk;

  key_entry_fsm #(.MAX_DIGITS(MAXD), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .SRCH(SRCH), .SRCL(SRCL), .DSTH(DSTH), .DSTL(DSTL),
    .ALU_OP(ALU_OP), .finish(finish), .entry_st(entry_st)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_src[$];
  int         m_dst[$];
  logic [7:0] m_op;
  int         m_phase;      // 0 entering SRC, 1 entering DST, 2 command complete
  bit         started = 1'b0;
  int         cyc_n = 0;
  bit         have_last = 1'b0;
  int         last_code = 0;
  int         last_acc = 0;
  logic [7:0] OPS [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};

  function automatic logic [15:0] fold(input int q[$]);
    logic [15:0] v = 16'h0000;
    foreach (q[i]) v = (v << 4) | 16'(q[i]);
    return v;
  endfunction

  function automatic bit m_accept(input int code);
`ifdef KEY_HOLDOFF_EN
    return !have_last || (code != last_code) || ((cyc_n - last_acc) > HOLD);
`else
    return (code >= 0);
`endif
  endfunction

  always @(posedge clk) begin
    int c;
    cyc_n++;
    c = int'(key_code);
    if (reset) begin
      m_src.delete(); m_dst.delete(); m_op = 8'h00; m_phase = 0;
      have_last = 1'b0; started = 1'b1;
    end else if (key_valid && m_accept(c)) begin
      have_last = 1'b1; last_code = c; last_acc = cyc_n;
      if (m_phase == 0) begin
        if (c <= 9) begin
          if (m_src.size() < MAXD) m_src.push_back(c);
        end else if (c <= 14) begin
          m_op = OPS[c-10]; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (c <= 9) begin
          if (m_dst.size() < MAXD) m_dst.push_back(c);
        end else if (c <= 14) begin
          if (m_dst.size() == 0) m_op = OPS[c-10];
        end else begin
          m_phase = 2;
        end
      end else begin
        if (c <= 9) begin
          m_src.delete(); m_dst.delete(); m_op = 8'h00;
          m_src.push_back(c); m_phase = 0;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("src",      {SRCH, SRCL},    fold(m_src));
      chk("dst",      {DSTH, DSTL},    fold(m_dst));
      chk("alu_op",   16'(ALU_OP),     16'(m_op));
      chk("finish",   16'(finish),     16'(m_phase == 2));
      chk("entry_st", 16'(entry_st),   16'(m_phase));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit r, input bit kv, input logic [3:0] c);
    @(posedge clk);
    #1;
    reset = r; key_valid = kv; key_code = c;
  endtask

  task automatic key(input logic [3:0] c);
    cyc(1'b0, 1'b1, c);
  endtask

  task automatic settle();
    cyc(1'b0, 1'b0, 4'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 4'd0);
    cyc(1'b0, 1'b0, 4'd0);
  endtask

  task automatic chk_all(input string t, input logic [15:0] s, input logic [15:0] d,
                         input logic [7:0] op, input logic f, input logic [1:0] st);
    chk({t, "_src"}, {SRCH, SRCL}, s);
    chk({t, "_dst"}, {DSTH, DSTL}, d);
    chk({t, "_op"},  16'(ALU_OP), 16'(op));
    chk({t, "_fin"}, 16'(finish), 16'(f));
    chk({t, "_st"},  16'(entry_st), 16'(st));
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk_all("reset", 16'h0000, 16'h0000, 8'h00, 1'b0, 2'd0);

    // 1: 1 2 + 3 =
    key(4'd1); key(4'd2); key(4'd10); key(4'd3); key(4'd15);
    settle();
    chk_all("t1", 16'h0012, 16'h0003, 8'h01, 1'b1, 2'd2);
    chk("t1_model_src", fold(m_src), 16'h0012);

    // 2: five digits then '-', fifth digit dropped; '=' in SRC ignored
    do_reset();
    key(4'd15); key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5); key(4'd11);
    settle();
    chk_all("t2", 16'h1234, 16'h0000, 8'h02, 1'b0, 2'd1);

    // 3: 7 + - AND 9 OR =
    do_reset();
    key(4'd7); key(4'd10); key(4'd11); key(4'd12); key(4'd9); key(4'd13); key(4'd15);
    settle();
    chk_all("t3", 16'h0007, 16'h0009, 8'h04, 1'b1, 2'd2);
    chk("t3_model_op", 16'(m_op), 16'h0004);

    // 4: digit in S_DONE starts a new command
    key(4'd6);
    settle();
    chk_all("t4", 16'h0006, 16'h0000, 8'h00, 1'b0, 2'd0);

    // 5: reset coincident with '=' after two digits
    do_reset();
    key(4'd4); key(4'd5);
    cyc(1'b1, 1'b1, 4'd15);
    settle();
    chk_all("t5", 16'h0000, 16'h0000, 8'h00, 1'b0, 2'd0);

`ifdef KEY_HOLDOFF_EN
    // 6: same key inside window dropped, after window accepted
    do_reset();
    for (int i = 0; i < 12; i++) cyc(1'b0, (i == 0) || (i == 3), 4'd5);
    @(negedge clk);
    chk("t6_window", {SRCH, SRCL}, 16'h0005);
    key(4'd5);
    settle();
    chk("t6_after", {SRCH, SRCL}, 16'h0055);
    do_reset();
    key(4'd5); key(4'd6);
    settle();
    chk("t6_diff", {SRCH, SRCL}, 16'h0056);
`endif

    // Random key streams with occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] c;
      if ($urandom_range(0, 3) == 0) c = key_code;
      else if ($urandom_range(0, 1) == 0) c = 4'($urandom_range(0, 9));
      else c = 4'($urandom_range(10, 15));
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, c);
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
